crc_faulty_memory: RTL



---
 rtl/crc_faulty_memory_pkg.sv | 24 ++
 rtl/crc_faulty_memory_if.sv | 39 +++
 rtl/crc_faulty_memory_engine.sv | 35 +++
 rtl/crc_faulty_memory.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/crc_faulty_memory_pkg.sv
// Shared types and constants for the CRC-protected faulty memory.
// Holds the controller state encoding, default generator polynomials and a width helper.
package crc_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_CALC,
    W_STORE,
    R_FETCH,
    R_CALC,
    R_DONE
  } state_e;

  localparam logic [3:0] POLY_CRC4 = 4'h3;   // x^4 + x + 1
  localparam logic [7:0] POLY_CRC8 = 8'h07;  // x^8 + x^2 + x + 1

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/crc_faulty_memory_if.sv
// Host command / status bundle for crc_faulty_memory.
// The host drives commands through the master modport; the memory implements the slave.
interface crc_faulty_memory_if
  import crc_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int CRC_W     = 4,
  parameter int BURST_W   = 2,
  parameter int ERR_CNT_W = 8
);
  localparam int FA_W = clog2(DATA_W + CRC_W);

  logic                 write;
  logic                 read;
  logic [DATA_W-1:0]    data_in;
  logic [ADDR_W-1:0]    addr_in;
  logic [FA_W-1:0]      fault_addr;
  logic [BURST_W-1:0]   burst_error_length;
  logic                 fault_enable;
  logic                 mem_write_busy;
  logic                 read_busy;
  logic                 data_valid;
  logic                 error_detected;
  logic [DATA_W-1:0]    data_out;
  logic [ERR_CNT_W-1:0] err_count;
  logic [ADDR_W-1:0]    err_addr;

  modport master (
    output write, read, data_in, addr_in, fault_addr, burst_error_length, fault_enable,
    input  mem_write_busy, read_busy, data_valid, error_detected, data_out, err_count, err_addr
  );

  modport slave (
    input  write, read, data_in, addr_in, fault_addr, burst_error_length, fault_enable,
    output mem_write_busy, read_busy, data_valid, error_detected, data_out, err_count, err_addr
  );

endinterface

// File: rtl/crc_faulty_memory_engine.sv
// Bit-serial CRC engine: one message bit per cycle, MSB first, zero init,
// no reflection and no final XOR. Shared by the write and read paths.
module crc_serial_engine
  import crc_mem_pkg::*;
#(
  parameter int               CRC_W = 4,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_CRC4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb    = r_crc[CRC_W-1] ^ bit_in;
  assign crc_out = r_crc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (clear) begin
      r_crc <= '0;
    end else if (shift_en) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_faulty_memory.sv
// CRC-protected memory with serial CRC generation/check and burst-fault injection on reads.
// Codeword = {data, crc}; faults are applied only to the fetched copy, never to storage.
module crc_faulty_memory
  import crc_mem_pkg::*;
#(
  parameter int               DATA_W     = 8,
  parameter int               ADDR_W     = 4,
  parameter int               CRC_W      = 4,
  parameter logic [CRC_W-1:0] POLY       = CRC_W'(POLY_CRC4),
  parameter int               BURST_W    = 2,
  parameter bit               WRAP_FAULT = 1'b0,
  parameter int               ERR_CNT_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  crc_faulty_memory_if.slave bus
);

  localparam int CW     = DATA_W + CRC_W;
  localparam int FA_W   = clog2(CW);
  localparam int CNT_W  = clog2(DATA_W + 1);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBURST = 1 << BURST_W;
  localparam int WIDE_W = CW + NBURST;

  state_e               r_state, w_state_nxt;
  logic [CW-1:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [DATA_W-1:0]    r_sh;
  logic [CNT_W-1:0]     r_cnt;
  logic [FA_W-1:0]      r_fault_addr;
  logic [BURST_W-1:0]   r_burst_len;
  logic                 r_fault_en;
  logic [CW-1:0]        r_cw;
  logic [DATA_W-1:0]    r_data_out;
  logic                 r_err;
  logic                 r_data_valid;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [ADDR_W-1:0]    r_err_addr;

  logic                 w_eng_clear;
  logic                 w_shift_en;
  logic                 w_bit_in;
  logic [CRC_W-1:0]     w_crc;
  logic [WIDE_W-1:0]    w_run;
  logic [WIDE_W-1:0]    w_wide;
  logic [CW-1:0]        w_mask;
  logic [CW-1:0]        w_faulted;
  logic                 w_mismatch;
  logic                 w_last_bit;

  crc_serial_engine #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_eng_clear),
    .shift_en (w_shift_en),
    .bit_in   (w_bit_in),
    .crc_out  (w_crc)
  );

  // Burst of (len+1) ones shifted to fault_addr; the overflow above the codeword MSB
  // is either folded back onto bit 0 or discarded.
  always_comb begin
    w_run  = ~({WIDE_W{1'b1}} << ({1'b0, r_burst_len} + (BURST_W+1)'(1)));
    w_wide = w_run << r_fault_addr;
    w_mask = '0;
    if ({1'b0, r_fault_addr} < (FA_W+1)'(CW)) begin
      w_mask = w_wide[CW-1:0];
      if (WRAP_FAULT) w_mask = w_mask | CW'(w_wide[WIDE_W-1:CW]);
    end
  end

  assign w_faulted  = r_mem[r_addr] ^ (r_fault_en ? w_mask : '0);
  assign w_mismatch = (w_crc != r_cw[CRC_W-1:0]);
  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_eng_clear = 1'b0;
    w_shift_en  = 1'b0;
    w_bit_in    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_eng_clear = 1'b1;
        if (bus.write)     w_state_nxt = W_CALC;
        else if (bus.read) w_state_nxt = R_FETCH;
      end
      W_CALC: begin
        w_shift_en = 1'b1;
        w_bit_in   = r_sh[DATA_W-1];
        if (w_last_bit) w_state_nxt = W_STORE;
      end
      W_STORE: w_state_nxt = IDLE;
      R_FETCH: begin
        // The first data bit goes straight from the faulted fetch into the engine.
        w_shift_en  = 1'b1;
        w_bit_in    = w_faulted[CW-1];
        w_state_nxt = R_CALC;
      end
      R_CALC: begin
        w_shift_en = 1'b1;
        w_bit_in   = r_sh[DATA_W-1];
        if (w_last_bit) w_state_nxt = R_DONE;
      end
      R_DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the memory array is cleared on reset because all-zero is a valid
  // codeword (CRC(0) = 0); reads after reset then report no error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_fault_addr <= '0;
      r_burst_len  <= '0;
      r_fault_en   <= 1'b0;
      r_cw         <= '0;
      r_data_out   <= '0;
      r_err        <= 1'b0;
      r_data_valid <= 1'b0;
      r_err_count  <= '0;
      r_err_addr   <= '0;
    end else begin
      r_data_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_addr       <= bus.addr_in;
          r_data       <= bus.data_in;
          r_sh         <= bus.data_in;
          r_fault_addr <= bus.fault_addr;
          r_burst_len  <= bus.burst_error_length;
          r_fault_en   <= bus.fault_enable;
          r_cnt        <= '0;
        end
        W_CALC, R_CALC: begin
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        W_STORE: r_mem[r_addr] <= {r_data, w_crc};
        R_FETCH: begin
          r_cw  <= w_faulted;
          r_sh  <= w_faulted[CW-1:CRC_W] << 1;
          r_cnt <= CNT_W'(1);
        end
        R_DONE: begin
          r_data_out   <= r_cw[CW-1:CRC_W];
          r_err        <= w_mismatch;
          r_data_valid <= 1'b1;
          if (w_mismatch) begin
            r_err_addr <= r_addr;
            if (r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_write_busy = (r_state == W_CALC)  || (r_state == W_STORE);
  assign bus.read_busy      = (r_state == R_FETCH) || (r_state == R_CALC) || (r_state == R_DONE);
  assign bus.data_valid     = r_data_valid;
  assign bus.error_detected = r_err;
  assign bus.data_out       = r_data_out;
  assign bus.err_count      = r_err_count;
  assign bus.err_addr       = r_err_addr;

endmodule
